// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM access arbiter: owners, FSM states, read tags.
// Optional statistics are enabled with the ARB_STATS_EN macro.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_HOST,
      OWN_STRM
   } owner_e;

   typedef enum logic {
      HOST_PRI,
      STRM_FORCE
   } arb_state_e;

   typedef struct packed {
      logic   vld;
      owner_e own;
   } rd_tag_t;

   localparam int RUN_CNT_W = 4;

   function automatic logic [RUN_CNT_W-1:0] sat_inc(
      input logic [RUN_CNT_W-1:0] v
   );
      return (&v) ? v : v + RUN_CNT_W'(1);
   endfunction

endpackage

// File: rtl/ram_arb_tag_pipe.sv
// In-flight read tag shift register, RD_LAT stages deep.
// Async clear drops every tag so no stale valid survives a reset.
module ram_arb_tag_pipe
   import ram_arb_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic    clk,
   input  logic    reset_n,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out
);

   rd_tag_t [DEPTH-1:0] pipe;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe <= '0;
      end else begin
         pipe[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/ram_access_arbiter.sv
// Arbitrates one RAM between an Avalon-MM host and a stream prefetcher.
// Define ARB_STATS_EN to add grant/stall statistics counters.
module ram_access_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 32,
   parameter int NSYM         = 4,
   parameter int RD_LAT       = 1,
   parameter int MAX_HOST_RUN = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              h_read,
   input  logic              h_write,
   input  logic [ADDR_W-1:0] h_address,
   input  logic [NSYM-1:0]   h_byteenable,
   input  logic [DATA_W-1:0] h_writedata,
   output logic              h_waitrequest,
   output logic [DATA_W-1:0] h_readdata,
   output logic              h_readdatavalid,
   input  logic              s_req,
   input  logic [ADDR_W-1:0] s_addr,
   output logic              s_grant,
   output logic [DATA_W-1:0] s_rdata,
   output logic              s_rvalid,
   output logic [ADDR_W-1:0] ram_rd_addr,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic [NSYM-1:0]   ram_we,
   input  logic [DATA_W-1:0] ram_dout
`ifdef ARB_STATS_EN
   ,
   input  logic              stat_clr,
   output logic [31:0]       stat_host_cnt,
   output logic [31:0]       stat_strm_cnt,
   output logic [31:0]       stat_stall_cnt
`endif
);

   localparam logic [RUN_CNT_W-1:0] MAX_C = RUN_CNT_W'(MAX_HOST_RUN);

   arb_state_e           state, state_nxt;
   logic [RUN_CNT_W-1:0] run_cnt, run_cnt_nxt;
   logic                 h_req, host_grant, strm_grant;
   logic                 h_wr_grant, h_rd_grant;
   logic [ADDR_W-1:0]    rd_addr_q, wr_addr_q;
   logic [DATA_W-1:0]    din_q, h_rd_q, s_rd_q;
   rd_tag_t              tag_in, tag_out;

   assign h_req = h_read | h_write;

   // Grants are forced low while reset is asserted.
   always_comb begin
      state_nxt   = state;
      run_cnt_nxt = run_cnt;
      host_grant  = 1'b0;
      strm_grant  = 1'b0;
      if (reset_n) begin
         unique case (state)
            HOST_PRI: begin
               if (h_req) begin
                  host_grant = 1'b1;
                  if (s_req) begin
                     run_cnt_nxt = sat_inc(run_cnt);
                     if (run_cnt_nxt >= MAX_C)
                        state_nxt = STRM_FORCE;
                  end else begin
                     run_cnt_nxt = '0;
                  end
               end else begin
                  strm_grant  = s_req;
                  run_cnt_nxt = '0;
               end
            end
            STRM_FORCE: begin
               strm_grant  = s_req;
               run_cnt_nxt = '0;
               state_nxt   = HOST_PRI;
            end
            default: begin
               state_nxt   = HOST_PRI;
               run_cnt_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= HOST_PRI;
         run_cnt <= '0;
      end else begin
         state   <= state_nxt;
         run_cnt <= run_cnt_nxt;
      end
   end

   assign h_wr_grant    = host_grant & h_write;
   assign h_rd_grant    = host_grant & h_read & ~h_write;
   assign h_waitrequest = ~reset_n | (h_req & ~host_grant);
   assign s_grant       = strm_grant;

   always_comb begin
      ram_rd_addr = rd_addr_q;
      if (h_rd_grant)
         ram_rd_addr = h_address;
      else if (strm_grant)
         ram_rd_addr = s_addr;
   end

   assign ram_wr_addr = h_wr_grant ? h_address : wr_addr_q;
   assign ram_din     = h_wr_grant ? h_writedata : din_q;
   assign ram_we      = h_wr_grant ? h_byteenable : '0;

   always_comb begin
      tag_in.vld = h_rd_grant | strm_grant;
      tag_in.own = OWN_NONE;
      if (h_rd_grant)
         tag_in.own = OWN_HOST;
      else if (strm_grant)
         tag_in.own = OWN_STRM;
   end

   ram_arb_tag_pipe #(
      .DEPTH (RD_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign h_readdatavalid = tag_out.vld & (tag_out.own == OWN_HOST);
   assign s_rvalid        = tag_out.vld & (tag_out.own == OWN_STRM);
   assign h_readdata      = h_readdatavalid ? ram_dout : h_rd_q;
   assign s_rdata         = s_rvalid ? ram_dout : s_rd_q;

   // Hold registers keep idle buses at their last driven value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         din_q     <= '0;
         h_rd_q    <= '0;
         s_rd_q    <= '0;
      end else begin
         rd_addr_q <= ram_rd_addr;
         wr_addr_q <= ram_wr_addr;
         din_q     <= ram_din;
         h_rd_q    <= h_readdata;
         s_rd_q    <= s_rdata;
      end
   end

`ifdef ARB_STATS_EN
   logic h_stall;
   assign h_stall = h_req & ~host_grant;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_host_cnt  <= '0;
         stat_strm_cnt  <= '0;
         stat_stall_cnt <= '0;
      end else if (stat_clr) begin
         stat_host_cnt  <= '0;
         stat_strm_cnt  <= '0;
         stat_stall_cnt <= '0;
      end else begin
         if (host_grant && !(&stat_host_cnt))
            stat_host_cnt <= stat_host_cnt + 32'd1;
         if (strm_grant && !(&stat_strm_cnt))
            stat_strm_cnt <= stat_strm_cnt + 32'd1;
         if (h_stall && !(&stat_stall_cnt))
            stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a byte-lane RAM model.
// Stats checks are built when ARB_STATS_EN is defined.
module tb_ram_access_arbiter;

   localparam int AW  = 16;
   localparam int DW  = 32;
   localparam int NS  = 4;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          h_read, h_write;
   logic [AW-1:0] h_address;
   logic [NS-1:0] h_byteenable;
   logic [DW-1:0] h_writedata;
   logic          h_waitrequest;
   logic [DW-1:0] h_readdata;
   logic          h_readdatavalid;
   logic          s_req;
   logic [AW-1:0] s_addr;
   logic          s_grant;
   logic [DW-1:0] s_rdata;
   logic          s_rvalid;
   logic [AW-1:0] ram_rd_addr, ram_wr_addr;
   logic [DW-1:0] ram_din, ram_dout;
   logic [NS-1:0] ram_we;
`ifdef ARB_STATS_EN
   logic          stat_clr;
   logic [31:0]   stat_host_cnt, stat_strm_cnt, stat_stall_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ram_access_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .NSYM         (NS),
      .RD_LAT       (LAT),
      .MAX_HOST_RUN (4)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .h_read          (h_read),
      .h_write         (h_write),
      .h_address       (h_address),
      .h_byteenable    (h_byteenable),
      .h_writedata     (h_writedata),
      .h_waitrequest   (h_waitrequest),
      .h_readdata      (h_readdata),
      .h_readdatavalid (h_readdatavalid),
      .s_req           (s_req),
      .s_addr          (s_addr),
      .s_grant         (s_grant),
      .s_rdata         (s_rdata),
      .s_rvalid        (s_rvalid),
      .ram_rd_addr     (ram_rd_addr),
      .ram_wr_addr     (ram_wr_addr),
      .ram_din         (ram_din),
      .ram_we          (ram_we),
      .ram_dout        (ram_dout)
`ifdef ARB_STATS_EN
      ,
      .stat_clr        (stat_clr),
      .stat_host_cnt   (stat_host_cnt),
      .stat_strm_cnt   (stat_strm_cnt),
      .stat_stall_cnt  (stat_stall_cnt)
`endif
   );

   // RAM model: read-old-data, LAT-cycle registered read.
   bit [31:0]   mem [256];
   bit          init_done = 1'b0;
   logic [31:0] rd_pipe [LAT];

   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
         init_done = 1'b1;
      end
      rd_pipe[0] <= mem[ram_rd_addr[7:0]];
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      for (int b = 0; b < NS; b++)
         if (ram_we[b]) mem[ram_wr_addr[7:0]][8*b +: 8] = ram_din[8*b +: 8];
   end

   assign ram_dout = rd_pipe[LAT-1];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      h_read  = 1'b0;
      h_write = 1'b0;
      s_req   = 1'b0;
   endtask

   initial begin
      reset_n      = 1'b0;
      h_read       = 1'b0;
      h_write      = 1'b0;
      h_address    = '0;
      h_byteenable = '0;
      h_writedata  = '0;
      s_req        = 1'b0;
      s_addr       = '0;
`ifdef ARB_STATS_EN
      stat_clr     = 1'b0;
`endif
      #3;
      chk("rst_wait", h_waitrequest, 1);
      chk("rst_sgnt", s_grant, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_hval", h_readdatavalid, 0);
      chk("rst_sval", s_rvalid, 0);
      chk("rst_rdad", ram_rd_addr, 0);
      #19;
      reset_n = 1'b1;
      #1;
      chk("idle_wait", h_waitrequest, 0);
      tick();

      // host write then read back
      h_write = 1'b1; h_address = 16'h0010;
      h_byteenable = 4'hF; h_writedata = 32'hDEAD_BEEF;
      #2;
      chk("wr_we", ram_we, 4'hF);
      chk("wr_wait", h_waitrequest, 0);
      chk("wr_addr", ram_wr_addr, 16'h0010);
      chk("wr_din", ram_din, 32'hDEAD_BEEF);
      tick();
      h_write = 1'b0; h_read = 1'b1;
      #2;
      chk("rd_wait", h_waitrequest, 0);
      chk("rd_addr", ram_rd_addr, 16'h0010);
      tick();
      h_read = 1'b0;
      #2;
      chk("rd_val_t1", h_readdatavalid, 0);
      tick();
      #2;
      chk("rd_val_t2", h_readdatavalid, 1);
      chk("rd_data", h_readdata, 32'hDEAD_BEEF);
      chk("rd_sval", s_rvalid, 0);
      tick();
      #2;
      chk("rd_val_t3", h_readdatavalid, 0);
      chk("rd_hold", h_readdata, 32'hDEAD_BEEF);

      // zero-enable write consumes slot; partial write
      h_write = 1'b1; h_byteenable = 4'h0; h_writedata = 32'h0;
      s_req = 1'b1; s_addr = 16'h0003;
      #2;
      chk("be0_we", ram_we, 0);
      chk("be0_wait", h_waitrequest, 0);
      chk("be0_sgnt", s_grant, 0);
      tick();
      s_req = 1'b0;
      h_byteenable = 4'h3; h_writedata = 32'h1234_5678;
      #2;
      chk("be3_we", ram_we, 4'h3);
      tick();
      idle();
      tick(); tick(); tick();

      // host/stream run-length pattern
      h_read = 1'b1; h_address = 16'h0010;
      s_req = 1'b1; s_addr = 16'h0020;
      for (int i = 0; i < 10; i++) begin
         #2;
         chk("run_sgnt", s_grant, (i % 5 == 4));
         chk("run_wait", h_waitrequest, (i % 5 == 4));
         tick();
      end
      idle();
      tick(); tick(); tick();

      // stream-only back-to-back reads
      for (int i = 0; i < 8 + LAT; i++) begin
         s_req  = (i < 8);
         s_addr = AW'(i);
         #2;
         chk("st_sgnt", s_grant, (i < 8));
         chk("st_hval", h_readdatavalid, 0);
         chk("st_sval", s_rvalid, (i >= LAT));
         if (i >= LAT)
            chk("st_data", s_rdata, 32'hA000_0000 | (i - LAT));
         tick();
      end
      idle();
      tick();

      // host read then stream read
      h_read = 1'b1; h_address = 16'h0010;
      #2;
      chk("mix_hgnt", h_waitrequest, 0);
      tick();
      h_read = 1'b0; s_req = 1'b1; s_addr = 16'h0005;
      #2;
      chk("mix_sgnt", s_grant, 1);
      tick();
      s_req = 1'b0;
      #2;
      chk("mix_hval", h_readdatavalid, 1);
      chk("mix_hdat", h_readdata, 32'hDEAD_5678);
      chk("mix_sv0", s_rvalid, 0);
      tick();
      #2;
      chk("mix_sval", s_rvalid, 1);
      chk("mix_sdat", s_rdata, 32'hA000_0005);
      chk("mix_hv0", h_readdatavalid, 0);
      chk("mix_hhold", h_readdata, 32'hDEAD_5678);
      tick();

      // read+write together: write wins, read dropped
      h_read = 1'b1; h_write = 1'b1; h_address = 16'h0030;
      h_byteenable = 4'hF; h_writedata = 32'h55AA_55AA;
      #2;
      chk("rw_we", ram_we, 4'hF);
      chk("rw_wait", h_waitrequest, 0);
      chk("rw_rdad", ram_rd_addr, 16'h0005);
      tick();
      idle();
      #2;
      chk("rw_v1", h_readdatavalid, 0);
      tick();
      #2;
      chk("rw_v2", h_readdatavalid, 0);
      tick();
      #2;
      chk("hold_rd", ram_rd_addr, 16'h0005);
      chk("hold_wr", ram_wr_addr, 16'h0030);
      chk("hold_we", ram_we, 0);
      chk("hold_din", ram_din, 32'h55AA_55AA);

      // reset with two reads in flight
      h_read = 1'b1; h_address = 16'h0010;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      chk("rr_wait", h_waitrequest, 1);
      chk("rr_hval", h_readdatavalid, 0);
      tick();
      h_read = 1'b0;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("rr_post", h_readdatavalid, 0);
         chk("rr_spost", s_rvalid, 0);
         tick();
      end

`ifdef ARB_STATS_EN
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      #2;
      chk("st_clr0", stat_host_cnt, 0);
      h_read = 1'b1; h_address = 16'h0010;
      s_req = 1'b1; s_addr = 16'h0020;
      for (int i = 0; i < 20; i++) tick();
      idle();
      #2;
      chk("st_host", stat_host_cnt, 16);
      chk("st_strm", stat_strm_cnt, 4);
      chk("st_stall", stat_stall_cnt, 4);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      #2;
      chk("clr_host", stat_host_cnt, 0);
      chk("clr_strm", stat_strm_cnt, 0);
      chk("clr_stall", stat_stall_cnt, 0);
`endif

      tick();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
